// File: rtl/divmod_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, iteration count
// and the quotient value reported on divide-by-zero.
package divmod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Widest operand the divide-by-zero constant covers.
  localparam int DBZ_MAX_W = 256;
  localparam logic [DBZ_MAX_W-1:0] DBZ_QUOTIENT = '1;

  function automatic int calc_iter(input int data_w, input int bits_per_cycle);
    return data_w / bits_per_cycle;
  endfunction

endpackage

// File: rtl/divmod_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference when it does not borrow.
module divmod_step #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DATAWIDTH-1:0] div_i,
  output logic [DATAWIDTH-1:0] rem_o,
  output logic                 qbit_o
);

  logic [DATAWIDTH:0] shifted;
  logic [DATAWIDTH:0] diff;

  // The partial remainder stays below the divisor, so the shifted value is
  // under twice the divisor and the top bit of the difference is the borrow.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, div_i};
  assign qbit_o  = ~diff[DATAWIDTH];
  assign rem_o   = qbit_o ? diff[DATAWIDTH-1:0] : shifted[DATAWIDTH-1:0];

endmodule

// File: rtl/divmod_seq.sv
// Iterative signed/unsigned divider producing quotient and remainder with
// valid/ready handshakes; DATAWIDTH up to DBZ_MAX_W, BITS_PER_CYCLE in {1,2,4}.
module divmod_seq
  import divmod_pkg::*;
#(
  parameter int DATAWIDTH      = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [DATAWIDTH-1:0] n,
  input  logic [DATAWIDTH-1:0] d,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] q,
  output logic [DATAWIDTH-1:0] r,
  output logic                 div_by_zero
);

  localparam int ITER  = calc_iter(DATAWIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [DATAWIDTH-1:0] DBZ_Q    = DBZ_QUOTIENT[DATAWIDTH-1:0];

  function automatic logic [DATAWIDTH-1:0] cond_neg(input logic [DATAWIDTH-1:0] v,
                                                    input logic                 neg);
    return neg ? (~v + DATAWIDTH'(1)) : v;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 accept;

  // dvd_q shifts the dividend magnitude out of its top and the quotient in
  // at its bottom; after ITER cycles it holds the quotient magnitude.
  logic [DATAWIDTH-1:0] dvd_q, dvd_d;
  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic [DATAWIDTH-1:0] dvs_q;
  logic [DATAWIDTH-1:0] n_q;
  logic                 neg_r_q;
  logic                 neg_q_q;
  logic                 zero_q;

  logic [DATAWIDTH-1:0] q_q, q_d;
  logic [DATAWIDTH-1:0] r_q, r_d;
  logic                 dbz_q, dbz_d;

  logic                 n_neg;
  logic                 d_neg;

  logic [DATAWIDTH-1:0]                rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0]           qbits;
  logic [DATAWIDTH+BITS_PER_CYCLE-1:0] dvd_shift;

  assign n_neg = is_signed & n[DATAWIDTH-1];
  assign d_neg = is_signed & d[DATAWIDTH-1];

  // Step j consumes dividend bit W-1-j; its quotient bit lands above later ones.
  assign rem_chain[0] = rem_q;

  for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
    divmod_step #(
      .DATAWIDTH(DATAWIDTH)
    ) u_step (
      .rem_i (rem_chain[j]),
      .bit_i (dvd_q[DATAWIDTH-1-j]),
      .div_i (dvs_q),
      .rem_o (rem_chain[j+1]),
      .qbit_o(qbits[BITS_PER_CYCLE-1-j])
    );
  end

  assign dvd_shift = {dvd_q, qbits};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_CALC;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = in_valid ? ST_CALC : ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    dvd_d = dvd_q;
    rem_d = rem_q;
    if (accept) begin
      dvd_d = cond_neg(n, n_neg);
      rem_d = '0;
    end else if (state_q == ST_CALC) begin
      dvd_d = dvd_shift[DATAWIDTH-1:0];
      rem_d = rem_chain[BITS_PER_CYCLE];
    end
  end

  // Operand state is meaningless outside an operation, so it carries no reset.
  always_ff @(posedge clk) begin
    dvd_q <= dvd_d;
    rem_q <= rem_d;
    if (accept) begin
      dvs_q   <= cond_neg(d, d_neg);
      n_q     <= n;
      neg_r_q <= n_neg;
      neg_q_q <= n_neg ^ d_neg;
      zero_q  <= (d == '0);
    end
  end

  always_comb begin
    q_d   = q_q;
    r_d   = r_q;
    dbz_d = dbz_q;
    if (state_q == ST_FIX) begin
      if (zero_q) begin
        q_d   = DBZ_Q;
        r_d   = n_q;
        dbz_d = 1'b1;
      end else begin
        q_d   = cond_neg(dvd_q, neg_q_q);
        r_d   = cond_neg(rem_q, neg_r_q);
        dbz_d = 1'b0;
      end
    end else if (state_q == ST_DONE && out_ready && !in_valid) begin
      q_d   = '0;
      r_d   = '0;
      dbz_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q   <= '0;
      r_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      r_q   <= r_d;
      dbz_q <= dbz_d;
    end
  end

  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule
